decomp_path_sched: RTL and testbench

DECOMP_PATH_SCHED -- requirements
Module: decomp_path_sched

---
 rtl/decomp_pkg.sv | 16 +
 rtl/axis_tag_stage.sv | 45 ++++
 rtl/decomp_path_sched.sv | 140 ++++++++++++++
 tb/tb_decomp_path_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// Shared definitions for the decompression path scheduler: FSM state
// encoding, path tag encoding and the default compressed-packet signature.
package decomp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BYP  = 2'd1,
    ST_DEC  = 2'd2
  } sched_state_t;

  localparam logic PATH_BYP = 1'b0;
  localparam logic PATH_DEC = 1'b1;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h5A44_4331;

endpackage

// File: rtl/axis_tag_stage.sv
// Single-entry AXI-stream register stage carrying data, keep, last and a
// one-bit path tag. Accepts a new beat whenever it is empty or its current
// beat is leaving in the same cycle, so it sustains one beat per cycle.
module axis_tag_stage #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              in_tag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              out_tag,
  output logic              out_valid,
  input  logic              out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load a new beat when there is room, otherwise drain or hold the current one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_tag   <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_tag   <= in_tag;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decomp_path_sched.sv
// Routes each packet of the upstream stream either to the decompression
// frontend or to the DMA bypass, based on a signature in the first beat.
// The route is latched for the whole packet. A single tagged output stage
// feeds both egresses, so only one egress valid can ever be asserted and a
// new packet to the other path waits until the previous last beat is sent.
// Optional per-path packet counters are built when
// DECOMP_PATH_SCHED_STATS_EN is defined.
module decomp_path_sched
  import decomp_pkg::*;
#(
  parameter int          DATA_W = 256,
  parameter int          KEEP_W = DATA_W / 8,
  parameter logic [31:0] MAGIC  = DEFAULT_MAGIC
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] byp_tdata,
  output logic [KEEP_W-1:0] byp_tkeep,
  output logic              byp_tvalid,
  output logic              byp_tlast,
  input  logic              byp_tready,
  output logic [DATA_W-1:0] dec_tdata,
  output logic [KEEP_W-1:0] dec_tkeep,
  output logic              dec_tvalid,
  output logic              dec_tlast,
  input  logic              dec_tready,
  input  logic              force_bypass,
  output logic              cur_path,
  output logic              busy
`ifdef DECOMP_PATH_SCHED_STATS_EN
  ,
  output logic [31:0]       pkt_cnt_byp,
  output logic [31:0]       pkt_cnt_dec
`endif
);

  sched_state_t state_q, state_d;

  logic              accept;
  logic              first_is_dec;
  logic              in_tag;
  logic              cur_path_q;
  logic [DATA_W-1:0] stage_data;
  logic [KEEP_W-1:0] stage_keep;
  logic              stage_last;
  logic              stage_tag;
  logic              stage_valid;
  logic              tagged_ready;

  assign accept       = s_tvalid && s_tready;
  assign first_is_dec = (s_tdata[31:0] == MAGIC) && (s_tkeep[3:0] == 4'hF) && !force_bypass;
  assign tagged_ready = (stage_tag == PATH_DEC) ? dec_tready : byp_tready;

  // Packet state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Classify first beats, keep the latched route for the rest of the packet.
  always_comb begin
    state_d = state_q;
    in_tag  = PATH_BYP;
    case (state_q)
      ST_IDLE: begin
        in_tag = first_is_dec ? PATH_DEC : PATH_BYP;
        if (accept && !s_tlast) state_d = first_is_dec ? ST_DEC : ST_BYP;
      end
      ST_BYP: begin
        in_tag = PATH_BYP;
        if (accept && s_tlast) state_d = ST_IDLE;
      end
      ST_DEC: begin
        in_tag = PATH_DEC;
        if (accept && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Remember the route chosen for the most recent packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                         cur_path_q <= PATH_BYP;
    else if (accept && state_q == ST_IDLE) cur_path_q <= in_tag;
  end

  axis_tag_stage #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W)
  ) u_stage (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_data  (s_tdata),
    .in_keep  (s_tkeep),
    .in_last  (s_tlast),
    .in_tag   (in_tag),
    .in_valid (s_tvalid),
    .in_ready (s_tready),
    .out_data (stage_data),
    .out_keep (stage_keep),
    .out_last (stage_last),
    .out_tag  (stage_tag),
    .out_valid(stage_valid),
    .out_ready(tagged_ready)
  );

  assign byp_tdata  = stage_data;
  assign byp_tkeep  = stage_keep;
  assign byp_tlast  = stage_last;
  assign byp_tvalid = stage_valid && (stage_tag == PATH_BYP);
  assign dec_tdata  = stage_data;
  assign dec_tkeep  = stage_keep;
  assign dec_tlast  = stage_last;
  assign dec_tvalid = stage_valid && (stage_tag == PATH_DEC);

  assign cur_path = cur_path_q;
  assign busy     = (state_q != ST_IDLE) || stage_valid;

`ifdef DECOMP_PATH_SCHED_STATS_EN
  logic sent_last;
  assign sent_last = stage_valid && tagged_ready && stage_last;

  // Count packets whose last beat has left on each path.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_byp <= '0;
      pkt_cnt_dec <= '0;
    end else if (sent_last) begin
      if (stage_tag == PATH_DEC) pkt_cnt_dec <= pkt_cnt_dec + 32'd1;
      else                       pkt_cnt_byp <= pkt_cnt_byp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decomp_path_sched.sv
// Directed self-checking bench for decomp_path_sched. Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point.
module tb_decomp_path_sched;

  localparam int          DATA_W = 256;
  localparam int          KEEP_W = 32;
  localparam logic [31:0] SIG    = 32'h5A44_4331;

  logic              aclk;
  logic              aresetn;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] byp_tdata;
  logic [KEEP_W-1:0] byp_tkeep;
  logic              byp_tvalid;
  logic              byp_tlast;
  logic              byp_tready;
  logic [DATA_W-1:0] dec_tdata;
  logic [KEEP_W-1:0] dec_tkeep;
  logic              dec_tvalid;
  logic              dec_tlast;
  logic              dec_tready;
  logic              force_bypass;
  logic              cur_path;
  logic              busy;
`ifdef DECOMP_PATH_SCHED_STATS_EN
  logic [31:0]       pkt_cnt_byp;
  logic [31:0]       pkt_cnt_dec;
`endif

  int checks;
  int errors;

  decomp_path_sched #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .MAGIC (SIG)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .byp_tdata   (byp_tdata),
    .byp_tkeep   (byp_tkeep),
    .byp_tvalid  (byp_tvalid),
    .byp_tlast   (byp_tlast),
    .byp_tready  (byp_tready),
    .dec_tdata   (dec_tdata),
    .dec_tkeep   (dec_tkeep),
    .dec_tvalid  (dec_tvalid),
    .dec_tlast   (dec_tlast),
    .dec_tready  (dec_tready),
    .force_bypass(force_bypass),
    .cur_path    (cur_path),
    .busy        (busy)
`ifdef DECOMP_PATH_SCHED_STATS_EN
    ,
    .pkt_cnt_byp (pkt_cnt_byp),
    .pkt_cnt_dec (pkt_cnt_dec)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [DATA_W-1:0] make_beat(input logic [31:0] lo, input logic [31:0] fill);
    return {{7{fill}}, lo};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic last, input logic fb);
    s_tdata      = d;
    s_tkeep      = '1;
    s_tlast      = last;
    force_bypass = fb;
    s_tvalid     = 1'b1;
  endtask

  task automatic drive_idle();
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    force_bypass = 1'b0;
  endtask

  // Reset values while held low, ready after release.
  task automatic test_reset();
    aresetn = 1'b0;
    drive_idle();
    s_tdata = '0; s_tkeep = '0;
    byp_tready = 1'b1; dec_tready = 1'b1;
    repeat (2) tick();
    checks++; if (byp_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_byp_valid: got %0b expected 0", byp_tvalid); end
    checks++; if (dec_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_dec_valid: got %0b expected 0", dec_tvalid); end
    checks++; if (cur_path !== 1'b0) begin errors++; $display("[TB] FAIL rst_cur_path: got %0b expected 0", cur_path); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b expected 0", busy); end
`ifdef DECOMP_PATH_SCHED_STATS_EN
    checks++; if (pkt_cnt_byp !== 32'd0 || pkt_cnt_dec !== 32'd0) begin errors++; $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", pkt_cnt_byp, pkt_cnt_dec); end
`endif
    aresetn = 1'b1;
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL rst_s_tready: got %0b expected 1", s_tready); end
  endtask

  // Three-beat signature packet goes to the decompressor, one cycle latency.
  task automatic test_dec_packet();
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = make_beat(SIG, 32'hA000_0000);
    d1 = make_beat(32'h0000_0011, 32'hA000_0001);
    d2 = make_beat(32'h0000_0022, 32'hA000_0002);
    drive_beat(d0, 1'b0, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL dec_b0_valid: got dec=%0b byp=%0b expected dec=1 byp=0", dec_tvalid, byp_tvalid); end
    checks++; if (dec_tdata !== d0 || dec_tlast !== 1'b0) begin errors++; $display("[TB] FAIL dec_b0_data: got %h last=%0b expected %h last=0", dec_tdata, dec_tlast, d0); end
    checks++; if (cur_path !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL dec_b0_status: got path=%0b busy=%0b expected 1/1", cur_path, busy); end
    drive_beat(d1, 1'b0, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0 || dec_tdata !== d1) begin errors++; $display("[TB] FAIL dec_b1: got dec=%0b byp=%0b data=%h expected 1/0 %h", dec_tvalid, byp_tvalid, dec_tdata, d1); end
    drive_beat(d2, 1'b1, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0 || dec_tdata !== d2 || dec_tlast !== 1'b1) begin errors++; $display("[TB] FAIL dec_b2: got dec=%0b byp=%0b last=%0b data=%h expected 1/0/1 %h", dec_tvalid, byp_tvalid, dec_tlast, dec_tdata, d2); end
    drive_idle();
    tick();
    checks++; if (dec_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL dec_drain: got dec=%0b busy=%0b expected 0/0", dec_tvalid, busy); end
  endtask

  // Two-beat packet with a zero first word goes to bypass only.
  task automatic test_bypass_packet();
    logic [DATA_W-1:0] d0, d1;
    d0 = make_beat(32'h0000_0000, 32'hB000_0000);
    d1 = make_beat(SIG, 32'hB000_0001);
    drive_beat(d0, 1'b0, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== d0) begin errors++; $display("[TB] FAIL byp_b0: got byp=%0b dec=%0b data=%h expected 1/0 %h", byp_tvalid, dec_tvalid, byp_tdata, d0); end
    checks++; if (cur_path !== 1'b0) begin errors++; $display("[TB] FAIL byp_cur_path: got %0b expected 0", cur_path); end
    drive_beat(d1, 1'b1, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== d1 || byp_tlast !== 1'b1) begin errors++; $display("[TB] FAIL byp_b1: got byp=%0b dec=%0b last=%0b data=%h expected 1/0/1 %h", byp_tvalid, dec_tvalid, byp_tlast, byp_tdata, d1); end
    drive_idle();
    tick();
    checks++; if (byp_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL byp_drain: got byp=%0b busy=%0b expected 0/0", byp_tvalid, busy); end
`ifdef DECOMP_PATH_SCHED_STATS_EN
    checks++; if (pkt_cnt_byp !== 32'd1 || pkt_cnt_dec !== 32'd1) begin errors++; $display("[TB] FAIL byp_counters: got %0d/%0d expected 1/1", pkt_cnt_byp, pkt_cnt_dec); end
`endif
  endtask

  // force_bypass sampled only on the first beat routes the whole packet to bypass.
  task automatic test_force_bypass();
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = make_beat(SIG, 32'hC000_0000);
    d1 = make_beat(SIG, 32'hC000_0001);
    d2 = make_beat(32'h0000_0033, 32'hC000_0002);
    drive_beat(d0, 1'b0, 1'b1);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== d0) begin errors++; $display("[TB] FAIL fb_b0: got byp=%0b dec=%0b data=%h expected 1/0 %h", byp_tvalid, dec_tvalid, byp_tdata, d0); end
    drive_beat(d1, 1'b0, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== d1) begin errors++; $display("[TB] FAIL fb_b1: got byp=%0b dec=%0b data=%h expected 1/0 %h", byp_tvalid, dec_tvalid, byp_tdata, d1); end
    drive_beat(d2, 1'b1, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tlast !== 1'b1 || cur_path !== 1'b0) begin errors++; $display("[TB] FAIL fb_b2: got byp=%0b dec=%0b last=%0b path=%0b expected 1/0/1/0", byp_tvalid, dec_tvalid, byp_tlast, cur_path); end
    drive_idle();
    tick();
  endtask

  // Decompressor back-pressure for 5 cycles stalls the input and holds the beat.
  task automatic test_stall();
    logic [DATA_W-1:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = make_beat((i == 0) ? SIG : 32'h0000_0040 + 32'(i), 32'hD000_0000 + 32'(i));
    drive_beat(d[0], 1'b0, 1'b0);
    tick();
    dec_tready = 1'b0;
    drive_beat(d[1], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_tready !== 1'b0 || dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0 || dec_tdata !== d[0]) begin errors++; $display("[TB] FAIL stall_hold%0d: got rdy=%0b dec=%0b byp=%0b data=%h expected 0/1/0 %h", i, s_tready, dec_tvalid, byp_tvalid, dec_tdata, d[0]); end
    end
    dec_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready: got %0b expected 1", s_tready); end
    tick();
    checks++; if (dec_tvalid !== 1'b1 || dec_tdata !== d[1]) begin errors++; $display("[TB] FAIL stall_b1: got dec=%0b data=%h expected 1 %h", dec_tvalid, dec_tdata, d[1]); end
    drive_beat(d[2], 1'b0, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || dec_tdata !== d[2]) begin errors++; $display("[TB] FAIL stall_b2: got dec=%0b data=%h expected 1 %h", dec_tvalid, dec_tdata, d[2]); end
    drive_beat(d[3], 1'b1, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || dec_tdata !== d[3] || dec_tlast !== 1'b1) begin errors++; $display("[TB] FAIL stall_b3: got dec=%0b last=%0b data=%h expected 1/1 %h", dec_tvalid, dec_tlast, dec_tdata, d[3]); end
    drive_idle();
    tick();
    checks++; if (dec_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got dec=%0b busy=%0b expected 0/0", dec_tvalid, busy); end
  endtask

  // Single-beat decomp packet immediately followed by single-beat bypass packet.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] a, b;
    a = make_beat(SIG, 32'hE000_0000);
    b = make_beat(32'h0000_0000, 32'hE000_0001);
    drive_beat(a, 1'b1, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0 || dec_tlast !== 1'b1 || cur_path !== 1'b1) begin errors++; $display("[TB] FAIL b2b_a: got dec=%0b byp=%0b last=%0b path=%0b expected 1/0/1/1", dec_tvalid, byp_tvalid, dec_tlast, cur_path); end
    drive_beat(b, 1'b1, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== b || cur_path !== 1'b0) begin errors++; $display("[TB] FAIL b2b_b: got byp=%0b dec=%0b path=%0b data=%h expected 1/0/0 %h", byp_tvalid, dec_tvalid, cur_path, byp_tdata, b); end
    // Same pair, but the decomp beat is held so the bypass beat must wait.
    drive_beat(a, 1'b1, 1'b0);
    tick();
    dec_tready = 1'b0;
    drive_beat(b, 1'b1, 1'b0);
    tick();
    checks++; if (dec_tvalid !== 1'b1 || byp_tvalid !== 1'b0 || s_tready !== 1'b0 || dec_tdata !== a) begin errors++; $display("[TB] FAIL b2b_wait: got dec=%0b byp=%0b rdy=%0b expected 1/0/0", dec_tvalid, byp_tvalid, s_tready); end
    dec_tready = 1'b1;
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== b) begin errors++; $display("[TB] FAIL b2b_after: got byp=%0b dec=%0b data=%h expected 1/0 %h", byp_tvalid, dec_tvalid, byp_tdata, b); end
    drive_idle();
    tick();
    checks++; if (busy !== 1'b0 || byp_tvalid !== 1'b0 || dec_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got busy=%0b byp=%0b dec=%0b expected 0/0/0", busy, byp_tvalid, dec_tvalid); end
`ifdef DECOMP_PATH_SCHED_STATS_EN
    checks++; if (pkt_cnt_byp !== 32'd4 || pkt_cnt_dec !== 32'd4) begin errors++; $display("[TB] FAIL b2b_counters: got %0d/%0d expected 4/4", pkt_cnt_byp, pkt_cnt_dec); end
`endif
  endtask

  // Reset after two of four beats drops the packet; next beat is a first beat.
  task automatic test_reset_mid_packet();
    logic [DATA_W-1:0] d0, d1, n;
    d0 = make_beat(SIG, 32'hF000_0000);
    d1 = make_beat(32'h0000_0055, 32'hF000_0001);
    n  = make_beat(32'h1234_5678, 32'hF000_0002);
    drive_beat(d0, 1'b0, 1'b0);
    tick();
    drive_beat(d1, 1'b0, 1'b0);
    tick();
    drive_idle();
    aresetn = 1'b0;
    #1;
    checks++; if (dec_tvalid !== 1'b0 || byp_tvalid !== 1'b0 || busy !== 1'b0 || cur_path !== 1'b0) begin errors++; $display("[TB] FAIL rmid_reset: got dec=%0b byp=%0b busy=%0b path=%0b expected 0/0/0/0", dec_tvalid, byp_tvalid, busy, cur_path); end
    tick();
    aresetn = 1'b1;
    drive_beat(n, 1'b1, 1'b0);
    tick();
    checks++; if (byp_tvalid !== 1'b1 || dec_tvalid !== 1'b0 || byp_tdata !== n || byp_tlast !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first: got byp=%0b dec=%0b last=%0b data=%h expected 1/0/1 %h", byp_tvalid, dec_tvalid, byp_tlast, byp_tdata, n); end
    drive_idle();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle: got busy=%0b expected 0", busy); end
`ifdef DECOMP_PATH_SCHED_STATS_EN
    checks++; if (pkt_cnt_byp !== 32'd1 || pkt_cnt_dec !== 32'd0) begin errors++; $display("[TB] FAIL rmid_counters: got %0d/%0d expected 1/0", pkt_cnt_byp, pkt_cnt_dec); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_dec_packet();
    test_bypass_packet();
    test_force_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
